// File: rtl/gpio_cfg_pkg.sv
// rtl/gpio_cfg_pkg.sv - shared types and constants for the GPIO pad config sequencer
// Purpose: pad configuration word layout, reset value and sequencer state encoding.
// Ports: none (package).
package gpio_cfg_pkg;

  localparam int CFG_W = 12;

  // Field order is MSB first so the packed struct matches the register bit map.
  typedef struct packed {
    logic       func_en;      // [11]
    logic       analog_pol;   // [10]
    logic       analog_sel;   // [9]
    logic       analog_en;    // [8]
    logic       holdover;     // [7]
    logic       slow_sel;     // [6]
    logic       vtrip_sel;    // [5]
    logic       ib_mode_sel;  // [4]
    logic       inp_dis;      // [3]
    logic [2:0] dm;           // [2:0]
  } pad_cfg_t;

  // Input-only drive mode, all other controls off.
  localparam pad_cfg_t CFG_RST = 12'h001;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PICK    = 3'd1,
    ISOLATE = 3'd2,
    APPLY   = 3'd3,
    SETTLE  = 3'd4,
    RELEASE = 3'd5
  } seq_state_e;

endpackage

// File: rtl/gpio_cfg_seq_rr_pick.sv
// rtl/gpio_cfg_seq_rr_pick.sv - rotating priority encoder for pending pads
// Purpose: find the first set pending bit at or after the round-robin pointer, wrapping.
// Ports:
//   i_pending  N-bit pending mask
//   i_rr_ptr   starting index (always < N)
//   o_sel      index of the selected pad
//   o_found    at least one pending bit is set
module gpio_rr_pick #(
  parameter int N  = 19,
  parameter int IW = 5
) (
  input  logic [N-1:0]  i_pending,
  input  logic [IW-1:0] i_rr_ptr,
  output logic [IW-1:0] o_sel,
  output logic          o_found
);

  logic [IW:0] w_idx;

  // Scan from the farthest offset down so the nearest pending pad is the last writer.
  always_comb begin
    o_sel   = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_rr_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(N)) begin
        w_idx = w_idx - (IW+1)'(N);
      end
      if (i_pending[w_idx[IW-1:0]]) begin
        o_sel   = w_idx[IW-1:0];
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_cfg_seq.sv
// rtl/gpio_cfg_seq.sv - per-pad GPIO configuration shadow registers and glitch-safe apply sequencer
// Purpose: holds a shadow config word per pad, applies changed words one pad at a time
//   (isolate, apply, settle, release) and muxes peripheral output data onto the pads.
// Ports:
//   mclk, reset                      clock, synchronous active-high reset
//   cfg_req/cfg_wr/cfg_addr/cfg_wdata register access request (held until cfg_ack)
//   cfg_rdata/cfg_ack                read data and one-cycle acknowledge
//   busy                             pads pending or sequencer active (registered)
//   func_out/func_oe/func_in         peripheral side of the pads
//   gpio_*                           pad-facing data, enables and static controls
module gpio_cfg_seq
  import gpio_cfg_pkg::*;
#(
  parameter int OPENFRAME_IO_PADS = 19,
  parameter int SETTLE_CYC        = 4
) (
  input  logic                         mclk,
  input  logic                         reset,
  input  logic                         cfg_req,
  input  logic                         cfg_wr,
  input  logic [4:0]                   cfg_addr,
  input  logic [CFG_W-1:0]             cfg_wdata,
  output logic [CFG_W-1:0]             cfg_rdata,
  output logic                         cfg_ack,
  output logic                         busy,
  input  logic [OPENFRAME_IO_PADS-1:0] func_out,
  input  logic [OPENFRAME_IO_PADS-1:0] func_oe,
  output logic [OPENFRAME_IO_PADS-1:0] func_in,
  input  logic [OPENFRAME_IO_PADS-1:0] gpio_in,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_out,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_oeb,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_inp_dis,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_dm2,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_dm1,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_dm0,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_ib_mode_sel,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_vtrip_sel,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_slow_sel,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_holdover,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_analog_en,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_analog_sel,
  output logic [OPENFRAME_IO_PADS-1:0] gpio_analog_pol
);

  localparam int       P    = OPENFRAME_IO_PADS;
  localparam int       CW   = $clog2(SETTLE_CYC + 1);
  localparam logic [5:0] P_W = 6'(P);

  pad_cfg_t         r_shadow [P];
  pad_cfg_t         r_active [P];
  logic [P-1:0]     r_pending;
  logic [P-1:0]     r_force;
  logic [4:0]       r_rr_ptr;
  logic [4:0]       r_sel;
  seq_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_ack;
  logic             r_busy;
  logic [CFG_W-1:0] r_rdata;

  logic [4:0]       w_pick_sel;
  logic             w_pick_found;
  logic             w_acc;
  logic             w_in_range;
  logic             w_wr_ok;

  // A held request is accepted only once: the ack cycle masks the next sample.
  assign w_acc      = cfg_req & ~r_ack;
  assign w_in_range = ({1'b0, cfg_addr} < P_W);
  assign w_wr_ok    = w_acc & cfg_wr & w_in_range;

  gpio_rr_pick #(
    .N  (P),
    .IW (5)
  ) u_pick (
    .i_pending (r_pending),
    .i_rr_ptr  (r_rr_ptr),
    .o_sel     (w_pick_sel),
    .o_found   (w_pick_found)
  );

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_pending <= '0;
      r_force   <= '0;
      r_rr_ptr  <= '0;
      r_sel     <= '0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= '0;
      for (int i = 0; i < P; i++) begin
        r_shadow[i] <= CFG_RST;
        r_active[i] <= CFG_RST;
      end
    end else begin
      r_ack  <= w_acc;
      r_busy <= (|r_pending) | (r_state != IDLE);
      if (w_acc) begin
        r_rdata <= w_in_range ? CFG_W'(r_shadow[cfg_addr]) : '0;
      end

      case (r_state)
        IDLE: begin
          if (|r_pending) r_state <= PICK;
        end
        PICK: begin
          if (w_pick_found) begin
            r_sel               <= w_pick_sel;
            r_force[w_pick_sel] <= 1'b1;
            r_cnt               <= CW'(SETTLE_CYC);
            r_state             <= ISOLATE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISOLATE: begin
          if (r_cnt == CW'(1)) r_state <= APPLY;
          else                 r_cnt   <= r_cnt - CW'(1);
        end
        APPLY: begin
          r_active[r_sel]  <= r_shadow[r_sel];
          r_pending[r_sel] <= 1'b0;
          r_cnt            <= CW'(SETTLE_CYC);
          r_state          <= SETTLE;
        end
        SETTLE: begin
          if (r_cnt == CW'(1)) r_state <= RELEASE;
          else                 r_cnt   <= r_cnt - CW'(1);
        end
        RELEASE: begin
          r_force[r_sel] <= 1'b0;
          r_rr_ptr       <= (r_sel == 5'(P - 1)) ? 5'd0 : r_sel + 5'd1;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Placed after the sequencer so a write landing in APPLY keeps the pad pending.
      if (w_wr_ok) begin
        r_shadow[cfg_addr]  <= pad_cfg_t'(cfg_wdata);
        r_pending[cfg_addr] <= 1'b1;
      end
    end
  end

  assign cfg_rdata = r_rdata;
  assign cfg_ack   = r_ack;
  assign busy      = r_busy;
  assign func_in   = gpio_in;

  for (genvar i = 0; i < P; i++) begin : g_pad
    assign gpio_dm0[i]         = r_active[i].dm[0];
    assign gpio_dm1[i]         = r_active[i].dm[1];
    assign gpio_dm2[i]         = r_active[i].dm[2];
    assign gpio_inp_dis[i]     = r_active[i].inp_dis;
    assign gpio_ib_mode_sel[i] = r_active[i].ib_mode_sel;
    assign gpio_vtrip_sel[i]   = r_active[i].vtrip_sel;
    assign gpio_slow_sel[i]    = r_active[i].slow_sel;
    assign gpio_holdover[i]    = r_active[i].holdover;
    assign gpio_analog_en[i]   = r_active[i].analog_en;
    assign gpio_analog_sel[i]  = r_active[i].analog_sel;
    assign gpio_analog_pol[i]  = r_active[i].analog_pol;
    assign gpio_out[i]         = r_active[i].func_en & func_out[i];
    assign gpio_oeb[i]         = r_force[i] | ~r_active[i].func_en | ~func_oe[i];
  end

endmodule
